mdu_seq: RTL

- Iterative multiply/divide unit for the multi-cycle MIPS core.
- Executes MULT/MULTU/DIV/DIVU as a 32-step shift-add or restoring-divide sequence and owns the HI/LO architectural registers.
- The main control FSM issues `start` and stalls on `busy`.
- MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write through this block.

---
 rtl/mdu_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; optional MDU_EARLY_OUT_EN shortens multiply RUN
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, m_q;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q, sign_r;
  // acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide
  logic               is_div, sgn, div0, last, early, run_end;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     madd;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, run_nxt, prod_f;
  logic [WIDTH-1:0]   quo_f, rem_f;
  // datapath arithmetic for one iteration and for the final sign fix-up
  always_comb begin
    is_div  = op_q[1];
    sgn     = ~op_q[0];
    mag_a   = (sgn & a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b   = (sgn & b_q[WIDTH-1]) ? -b_q : b_q;
    div0    = is_div && (b_q == '0);
    last    = cnt == CNT_W'(WIDTH - 1);
    madd    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
    mul_nxt = {madd, acc[WIDTH-1:1]};
    trial   = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, m_q};
    div_nxt = trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_f  = sign_q ? -acc : acc;
    quo_f   = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_f   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MDU_EARLY_OUT_EN
    // after cnt+1 steps the low WIDTH-(cnt+1) bits of acc are the unconsumed multiplier bits
    early   = !is_div && ((mul_nxt[WIDTH-1:0] & ({WIDTH{1'b1}} >> (cnt + 1'b1))) == '0);
    run_end = last || early;
    run_nxt = is_div ? div_nxt : (early ? mul_nxt >> (CNT_W'(WIDTH) - (cnt + 1'b1)) : mul_nxt);
`else
    early   = 1'b0;
    run_end = last || early;
    run_nxt = is_div ? div_nxt : mul_nxt;
`endif
  end
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? PREP : IDLE;
      PREP:    state_nxt = div0 ? DONE : RUN;
      RUN:     state_nxt = run_end ? FIX : RUN;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // operand capture, iteration and HI/LO update
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= A;
            b_q  <= B;
          end
          if (we_hi) hi <= wdata;
          if (we_lo) lo <= wdata;
        end
        PREP: begin
          sign_q <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= sgn & a_q[WIDTH-1];
          cnt    <= '0;
          acc    <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
          m_q    <= is_div ? mag_b : mag_a;
          if (div0) begin
            hi <= a_q;
            lo <= '1;
          end
        end
        RUN: begin
          acc <= run_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi <= is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];
          lo <= is_div ? quo_f : prod_f[WIDTH-1:0];
        end
        default: ;
      endcase
    end
endmodule
